// File: rtl/alu_writeback_stage.sv
// Writeback buffer between the ALU and the register-file write port.
// Queues results in a small FIFO and owns the architectural Z/C flags.
module alu_writeback_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_result,
  input  logic                       in_zero,
  input  logic                       in_carry,
  input  logic [ADDR_W-1:0]          in_rd,
  input  logic                       in_upd_z,
  input  logic                       in_upd_c,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [ADDR_W-1:0]          out_rd,
  output logic                       flag_z,
  output logic                       flag_c,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [ADDR_W-1:0] r_mem_rd   [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_flag_z;
  logic              r_flag_c;
  logic [DATA_W-1:0] r_hold_data;
  logic [ADDR_W-1:0] r_hold_rd;

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head_data;
  logic [ADDR_W-1:0] w_head_rd;

  // Ready comes only from occupancy, so there is no combinational path from out_ready.
  assign in_ready    = (r_count < CNT_MAX);
  assign out_valid   = (r_count != '0);
  assign w_accept    = in_valid & in_ready;
  assign w_push      = w_accept & (in_rd != '0);
  assign w_pop       = out_valid & out_ready;
  assign w_head_data = r_mem_data[r_rptr];
  assign w_head_rd   = r_mem_rd[r_rptr];

  // When empty, present the last popped entry so out_* hold their previous value.
  assign out_data = out_valid ? w_head_data : r_hold_data;
  assign out_rd   = out_valid ? w_head_rd   : r_hold_rd;
  assign flag_z   = r_flag_z;
  assign flag_c   = r_flag_c;
  assign count    = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else if (w_accept) begin
      if (in_upd_z) r_flag_z <= in_zero;
      if (in_upd_c) r_flag_c <= in_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_rd[i]   <= '0;
      end
    end else if (w_push) begin
      r_mem_data[r_wptr] <= in_result;
      r_mem_rd[r_wptr]   <= in_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_data <= '0;
      r_hold_rd   <= '0;
    end else if (w_pop) begin
      r_hold_data <= w_head_data;
      r_hold_rd   <= w_head_rd;
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: reset, single pass, full/backpressure,
// register-0 drop, flag selectivity, streaming push/pop with wrap, async reset.
module tb_alu_writeback_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic       in_zero;
  logic       in_carry;
  logic [2:0] in_rd;
  logic       in_upd_z;
  logic       in_upd_c;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_rd;
  logic       flag_z;
  logic       flag_c;
  logic [1:0] count;

  int n_assert;
  int n_fail;

  alu_writeback_stage #(.DATA_W(8), .ADDR_W(3), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_zero   (in_zero),
    .in_carry  (in_carry),
    .in_rd     (in_rd),
    .in_upd_z  (in_upd_z),
    .in_upd_c  (in_upd_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] res, input logic [2:0] rd,
                       input logic z, input logic c, input logic uz, input logic uc);
    in_valid  = v;
    in_result = res;
    in_rd     = rd;
    in_zero   = z;
    in_carry  = c;
    in_upd_z  = uz;
    in_upd_c  = uc;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle();
    #2;
    chk("rst_count",  32'(count),     32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_iready", 32'(in_ready),  32'd1);
    chk("rst_odata",  32'(out_data),  32'h0);
    chk("rst_flags",  32'({flag_z, flag_c}), 32'd0);
    #10 rst_n = 1'b1;

    // Single pass
    out_ready = 1'b1;
    drive(1'b1, 8'h3C, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    chk("sp_ovalid", 32'(out_valid), 32'd1);
    chk("sp_odata",  32'(out_data),  32'h3C);
    chk("sp_ord",    32'(out_rd),    32'd5);
    chk("sp_flagc",  32'(flag_c),    32'd1);
    chk("sp_flagz",  32'(flag_z),    32'd0);
    tick();
    chk("sp_drain_ovalid", 32'(out_valid), 32'd0);
    chk("sp_hold_odata",   32'(out_data),  32'h3C);
    chk("sp_hold_ord",     32'(out_rd),    32'd5);

    // Backpressure and full
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h22, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("full_count",  32'(count),    32'd2);
    chk("full_iready", 32'(in_ready), 32'd0);
    chk("full_head",   32'(out_data), 32'h11);
    drive(1'b1, 8'h33, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    chk("full_ign_flagz", 32'(flag_z),   32'd0);
    chk("full_ign_count", 32'(count),    32'd2);
    chk("full_stable",    32'(out_data), 32'h11);
    chk("full_stable_rd", 32'(out_rd),   32'd1);
    out_ready = 1'b1;
    #1;
    chk("pop1_data", 32'(out_data), 32'h11);
    tick();
    chk("pop1_count",  32'(count),    32'd1);
    chk("pop1_iready", 32'(in_ready), 32'd1);
    chk("pop2_data",   32'(out_data), 32'h22);
    chk("pop2_rd",     32'(out_rd),   32'd2);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Register 0 drop
    out_ready = 1'b0;
    drive(1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    chk("r0_flagz",  32'(flag_z),    32'd1);
    chk("r0_count",  32'(count),     32'd0);
    chk("r0_ovalid", 32'(out_valid), 32'd0);

    // Flag selectivity (rd=0 so nothing is queued)
    drive(1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("fs_clr_c", 32'({flag_z, flag_c}), 32'b10);
    drive(1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fs_noupd_c", 32'({flag_z, flag_c}), 32'b10);
    drive(1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("fs_z0", 32'({flag_z, flag_c}), 32'b00);
    drive(1'b1, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    chk("fs_z1_only", 32'({flag_z, flag_c}), 32'b10);
    tick();
    chk("fs_hold", 32'({flag_z, flag_c}), 32'b10);

    // Streaming push/pop at count=1, pointers wrap repeatedly
    drive(1'b1, 8'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("st_prime", 32'(count), 32'd1);
    out_ready = 1'b1;
    for (int i = 2; i <= 11; i++) begin
      drive(1'b1, 8'(i), 3'((i % 7) + 1), 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("st_head", 32'(out_data), 32'(i - 1));
      tick();
      chk("st_count", 32'(count), 32'd1);
      chk("st_rd",    32'(out_rd), 32'((i % 7) + 1));
    end
    idle();
    tick();
    chk("st_drain", 32'(out_valid), 32'd0);
    chk("st_hold",  32'(out_data),  32'd11);

    // Asynchronous reset mid-stream with two entries queued
    out_ready = 1'b0;
    drive(1'b1, 8'hA5, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 8'h5A, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    chk("pre_rst_count", 32'(count), 32'd2);
    chk("pre_rst_flags", 32'({flag_z, flag_c}), 32'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count",  32'(count),     32'd0);
    chk("arst_ovalid", 32'(out_valid), 32'd0);
    chk("arst_iready", 32'(in_ready),  32'd1);
    chk("arst_flags",  32'({flag_z, flag_c}), 32'b00);
    chk("arst_out",    32'({out_data, 5'(out_rd)}), 32'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 8'h77, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("post_rst_data",  32'(out_data), 32'h77);
    chk("post_rst_count", 32'(count),    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
